// File: rtl/vram_arbiter.sv
// vram_arbiter: video/CPU VRAM arbiter with buffered CPU writes; define VRAM_ARB_FWD_EN to forward CPU reads from the write buffer
module vram_arbiter #(
  parameter int AW = 15,
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  output logic [DW-1:0] vid_dout,
  input  logic          cpu_rd_req,
  input  logic [AW-1:0] cpu_rd_addr,
  output logic          cpu_rd_valid,
  output logic [DW-1:0] cpu_rd_data,
  input  logic          cpu_wr_req,
  input  logic [AW-1:0] cpu_wr_addr,
  input  logic [DW-1:0] cpu_wr_data,
  output logic          cpu_wr_full,
  output logic          wr_ovf,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} state_t;
  state_t state, state_d;
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_d;
  logic hit, pend, push, pop, rd_busy;
  logic [DW-1:0] vid_hold, rd_hold, rd_now;
`ifdef VRAM_ARB_FWD_EN
  logic fwd, fwd_q, fwd_v;
  logic [DW-1:0] fwd_data, fwd_q_data, fwd_v_data;
`endif
  // search valid buffer entries oldest to newest so the last match is the newest one
  always_comb begin
    hit = 1'b0;
`ifdef VRAM_ARB_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (CW'(i) < cnt && fifo_addr[rd_ptr + PW'(i)] == cpu_rd_addr) begin
        hit = 1'b1;
`ifdef VRAM_ARB_FWD_EN
        fwd_data = fifo_data[rd_ptr + PW'(i)];
`endif
      end
  end
  // pick this cycle's memory op: video first, then a non-hitting read, else drain the oldest write
  always_comb begin
    rd_busy = state == CPU_RD || cpu_rd_valid;
`ifdef VRAM_ARB_FWD_EN
    rd_busy = rd_busy || fwd_q;
`endif
    pend = cpu_rd_req && !rd_busy;
    push = cpu_wr_req && !cpu_wr_full;
    state_d = vid_req ? VID : (pend && !hit) ? CPU_RD : (cnt != '0) ? CPU_WR : IDLE;
    pop = state_d == CPU_WR;
    cnt_d = cnt + CW'(push) - CW'(pop);
`ifdef VRAM_ARB_FWD_EN
    fwd = pend && hit;
`endif
  end
  // read data returned this cycle, and held copies between pulses
  always_comb begin
    rd_now = mem_dout;
`ifdef VRAM_ARB_FWD_EN
    rd_now = fwd_v ? fwd_v_data : mem_dout;
`endif
    vid_dout = vid_valid ? mem_dout : vid_hold;
    cpu_rd_data = cpu_rd_valid ? rd_now : rd_hold;
  end
  // op issued last cycle; it is what the RAM is serving now
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  // registered RAM port; idle cycles leave address and data untouched
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_din <= '0;
    end else begin
      mem_we <= state_d == CPU_WR;
      if (state_d == VID) mem_addr <= vid_addr;
      else if (state_d == CPU_RD) mem_addr <= cpu_rd_addr;
      else if (state_d == CPU_WR) begin
        mem_addr <= fifo_addr[rd_ptr];
        mem_din <= fifo_data[rd_ptr];
      end
    end
  end
  // write buffer pointers, occupancy, full flag and sticky overflow
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      cpu_wr_full <= 1'b0;
      wr_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt_d;
      cpu_wr_full <= cnt_d == CW'(FIFO_DEPTH);
      if (cpu_wr_req && cpu_wr_full) wr_ovf <= 1'b1;
    end
  end
  // write buffer storage; entries beyond the count are simply stale
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_wr_addr;
      fifo_data[wr_ptr] <= cpu_wr_data;
    end
  end
  // completion pulses two cycles after issue, plus held read results
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vid_valid <= 1'b0;
      cpu_rd_valid <= 1'b0;
      vid_hold <= '0;
      rd_hold <= '0;
    end else begin
      vid_valid <= state == VID;
`ifdef VRAM_ARB_FWD_EN
      cpu_rd_valid <= state == CPU_RD || fwd_q;
`else
      cpu_rd_valid <= state == CPU_RD;
`endif
      if (vid_valid) vid_hold <= mem_dout;
      if (cpu_rd_valid) rd_hold <= rd_now;
    end
  end
`ifdef VRAM_ARB_FWD_EN
  // forwarded read data rides a two-stage pipe to line up with memory-read latency
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fwd_q <= 1'b0;
      fwd_v <= 1'b0;
      fwd_q_data <= '0;
      fwd_v_data <= '0;
    end else begin
      fwd_q <= fwd;
      fwd_v <= fwd_q;
      fwd_q_data <= fwd_data;
      fwd_v_data <= fwd_q_data;
    end
  end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed checks of vram_arbiter against a queue-based reference model
module tb_vram_arbiter;
  localparam int D = 4;
`ifdef VRAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk_sys = 1'b0, reset = 1'b1;
  logic vid_req = 1'b0, cpu_rd_req = 1'b0, cpu_wr_req = 1'b0;
  logic [14:0] vid_addr = '0, cpu_rd_addr = '0, cpu_wr_addr = '0;
  logic [7:0] cpu_wr_data = '0;
  logic vid_valid, cpu_rd_valid, cpu_wr_full, wr_ovf, mem_we;
  logic [7:0] vid_dout, cpu_rd_data, mem_din, mem_dout;
  logic [14:0] mem_addr;
  int n_cmp = 0, n_err = 0;
  bit vid_last = 1'b0, vid_q = 1'b0;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_dout(vid_dout),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_full(cpu_wr_full), .wr_ovf(wr_ovf),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [7:0] init_val(input logic [14:0] a);
    return a == 15'h1800 ? 8'h47 : a[7:0] ^ a[14:7];
  endfunction

  logic [7:0] ram [32768];
  bit ram_w [32768];
  always @(posedge clk_sys) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_din;
      ram_w[mem_addr] <= 1'b1;
    end
    mem_dout <= ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  always @(posedge clk_sys) begin
    assert (!(vid_req && vid_q)) else $error("vid_req back-to-back");
    vid_q <= vid_req;
  end

  // reference model: architectural memory, latest-accepted-write shadow, and a queue of buffered writes
  typedef struct packed {logic [14:0] a; logic [7:0] d;} ent_t;
  ent_t q[$];
  logic [7:0] mm [32768];
  bit mm_w [32768];
  logic [7:0] sh [32768];
  bit sh_w [32768];
  int rd_left;
  bit p_vid, p_rd;
  logic [7:0] p_vid_d, p_rd_d;
  logic [14:0] e_mem_addr;
  logic e_mem_we, e_vid_valid, e_rd_valid, e_full, e_ovf;
  logic [7:0] e_mem_din, e_vid_dout, e_rd_data;

  function automatic logic [7:0] rd_mm(input logic [14:0] a);
    return mm_w[a] ? mm[a] : init_val(a);
  endfunction
  function automatic logic [7:0] rd_sh(input logic [14:0] a);
    return sh_w[a] ? sh[a] : rd_mm(a);
  endfunction

  task automatic model_reset();
    q.delete();
    rd_left = 0; p_vid = 0; p_rd = 0; p_vid_d = '0; p_rd_d = '0;
    e_mem_addr = '0; e_mem_we = 0; e_mem_din = '0; e_vid_valid = 0; e_vid_dout = '0;
    e_rd_valid = 0; e_rd_data = '0; e_full = 0; e_ovf = 0;
  endtask

  task automatic model_step();
    bit pend, hit;
    int op, sz0;
    if (reset) begin
      model_reset();
      return;
    end
    e_vid_valid = p_vid;
    if (p_vid) e_vid_dout = p_vid_d;
    e_rd_valid = p_rd;
    if (p_rd) e_rd_data = p_rd_d;
    sz0 = q.size();
    pend = cpu_rd_req && rd_left == 0;
    hit = 0;
    foreach (q[i]) if (q[i].a == cpu_rd_addr) hit = 1;
    op = vid_req ? 1 : (pend && !hit) ? 2 : (sz0 > 0) ? 3 : 0;
    p_vid = op == 1;
    p_vid_d = rd_mm(vid_addr);
    p_rd = op == 2 || (FWD && pend && hit);
    p_rd_d = rd_sh(cpu_rd_addr);
    rd_left = p_rd ? 2 : (rd_left > 0 ? rd_left - 1 : 0);
    e_mem_we = op == 3;
    if (op == 1) e_mem_addr = vid_addr;
    if (op == 2) e_mem_addr = cpu_rd_addr;
    if (op == 3) begin
      e_mem_addr = q[0].a;
      e_mem_din = q[0].d;
      mm[q[0].a] = q[0].d;
      mm_w[q[0].a] = 1'b1;
      void'(q.pop_front());
    end
    if (cpu_wr_req) begin
      if (sz0 == D) e_ovf = 1;
      else begin
        q.push_back({cpu_wr_addr, cpu_wr_data});
        sh[cpu_wr_addr] = cpu_wr_data;
        sh_w[cpu_wr_addr] = 1'b1;
      end
    end
    e_full = q.size() == D;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("mem_we", mem_we, e_mem_we);
    check("mem_addr", mem_addr, e_mem_addr);
    check("mem_din", mem_din, e_mem_din);
    check("vid_valid", vid_valid, e_vid_valid);
    check("vid_dout", vid_dout, e_vid_dout);
    check("rd_valid", cpu_rd_valid, e_rd_valid);
    check("rd_data", cpu_rd_data, e_rd_data);
    check("wr_full", cpu_wr_full, e_full);
    check("wr_ovf", wr_ovf, e_ovf);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    vid_req = 0;
    cpu_wr_req = 0;
    check_all();
    if (e_rd_valid) cpu_rd_req = 0;
  endtask

  task automatic push(input logic [14:0] a, input logic [7:0] d);
    cpu_wr_req = 1; cpu_wr_addr = a; cpu_wr_data = d;
  endtask

  task automatic wait_rd(input string tag, input logic [7:0] exp);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      vid_req = i % 2 == 1;
      vid_addr = 15'h1801;
      tick();
      if (cpu_rd_valid) begin
        seen = 1;
        check(tag, cpu_rd_data, exp);
      end
    end
    check({tag, "_seen"}, seen, 1);
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_sys);
    check_all();
    reset = 0;
    // single video fetch: address at +1, byte at +2
    vid_req = 1; vid_addr = 15'h1800;
    tick();
    check("t1_addr", mem_addr, 15'h1800);
    check("t1_we", mem_we, 0);
    tick();
    check("t1_vvalid", vid_valid, 1);
    check("t1_vdout", vid_dout, 8'h47);
    tick();
    // write burst against alternating video: fills, overflows, then drains in order
    for (int i = 0; i < 10; i++) begin
      push(15'h4000 + 15'(i), 8'hA0 + 8'(i));
      vid_req = i % 2 == 0;
      vid_addr = 15'h1800 + 15'(i);
      tick();
    end
    check("t2_ovf", wr_ovf, 1);
    repeat (6) tick();
    check("t2_drained", cpu_wr_full, 0);
    // buffered write followed at once by a read of the same address
    push(15'h0100, 8'h55);
    tick();
    cpu_rd_req = 1; cpu_rd_addr = 15'h0100;
    wait_rd("t4_rd", 8'h55);
    // two writes to one address, read returns the newer one
    push(15'h0200, 8'h11);
    tick();
    push(15'h0200, 8'h22);
    tick();
    cpu_rd_req = 1; cpu_rd_addr = 15'h0200;
    wait_rd("t5_rd", 8'h22);
    // reset with writes buffered and a read in flight
    for (int i = 0; i < 4; i++) begin
      push(15'h0500 + 15'(i), 8'(i));
      vid_req = i % 2 == 0;
      if (i == 1) begin cpu_rd_req = 1; cpu_rd_addr = 15'h0300; end
      tick();
    end
    reset = 1; cpu_rd_req = 0;
    repeat (3) tick();
    check("t6_we", mem_we, 0);
    check("t6_rdv", cpu_rd_valid, 0);
    check("t6_full", cpu_wr_full, 0);
    reset = 0;
    tick();
    cpu_rd_req = 1; cpu_rd_addr = 15'h7777;
    wait_rd("t6_rd", init_val(15'h7777));
    // randomized traffic
    vid_last = 0;
    for (int n = 0; n < 800; n++) begin
      vid_req = !vid_last && $urandom_range(0, 1) == 1;
      vid_last = vid_req;
      vid_addr = 15'h0100 + 15'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) push(15'h0100 + 15'($urandom_range(0, 7)), 8'($urandom));
      if (!cpu_rd_req && $urandom_range(0, 3) == 0) begin
        cpu_rd_req = 1;
        cpu_rd_addr = 15'h0100 + 15'($urandom_range(0, 7));
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
